if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline; producer of the pc/inst pair consumed by the decode stage, and consumer of that stage's redirect outputs (pcsrc, imm, rs value).
- Owns the fetch PC, the instruction-memory request handshake, a one-entry hold buffer for stalls, and the IF/ID pipeline register.
- No branch delay slot: the instruction in flight behind a taken redirect is squashed.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0000, instruction word driven on bubbles (decodes to aluop 0, no reads)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit; hold IF/ID contents
pcsrc  in  2  from decode: 0 PC+4, 1 branch, 2 jump, 3 jump-register
branch_taken  in  1  branch condition result for current ID instruction (used only when pcsrc==1)
imm  in  32  decode-computed branch/jump target
rs_data  in  32  forwarded rs value for pcsrc==3
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  response valid this cycle; variable latency, may equal request cycle
imem_rdata  in  32  instruction word, valid when imem_ready
pc  out  32  IF/ID pc
inst  out  32  IF/ID instruction
inst_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: pc=0, inst=NOP_INST, inst_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, state=REQ, hold buffer empty. rst overrides all other inputs, including mid-transaction; a late imem_ready from the aborted request is ignored (state DRAIN is not entered from reset).
- Redirect (take): inst_valid & !stall & (pcsrc==2 | pcsrc==3 | (pcsrc==1 & branch_taken)).
  - Target: imm for pcsrc 1/2; {rs_data[31:2],2'b00} for pcsrc 3.
  - Redirect while stall=1 is ignored; decode re-presents it.
- FSM states: REQ, HOLD, DRAIN.
- REQ:
  - imem_req=1; imem_addr=fetch_pc, stable until imem_ready.
  - ready & !stall & !take: IF/ID <= {fetch_pc, rdata, 1}; fetch_pc += 4.
  - ready & stall: word -> hold buffer; HOLD; fetch_pc += 4.
  - ready & take: discard word; IF/ID bubble (NOP_INST, valid 0); fetch_pc <= target; stay REQ.
  - !ready & take: fetch_pc <= target; bubble IF/ID; DRAIN.
  - !ready & !stall & !take: bubble IF/ID (valid 0).
  - !ready & stall: IF/ID unchanged.
- HOLD:
  - imem_req=0.
  - !stall & !take: IF/ID <= hold buffer; REQ.
  - take: discard buffer; fetch_pc <= target; bubble; REQ.
- DRAIN:
  - imem_req=1; imem_addr = the original address, kept until the old request completes.
  - ready: discard word; REQ with the new fetch_pc.
  - Further takes in DRAIN overwrite fetch_pc.
- Latency: zero-wait memory gives one instruction per cycle; the redirect penalty is one bubble.
- Stall with IF/ID holding a bubble: bubble retained.
- Wrap: fetch_pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- pc/inst/inst_valid change only on clk edges. imem_req/imem_addr are registered or purely state/fetch_pc derived, with no combinational path from stall.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0.
  - fetch_cnt increments on every edge where a valid instruction is loaded into IF/ID.
  - bubble_cnt increments on every edge where IF/ID is loaded with a bubble (stall=0, valid 0).
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Zero-wait memory (ready=1 every cycle), rst high 2 cycles then low -> imem_addr 0,4,8,C on consecutive cycles; IF/ID pc 0,4,8 with matching rdata and inst_valid=1 from the second cycle.
- 3-cycle memory latency -> imem_addr held at 0x4 for 3 cycles; two bubbles then {pc=4, inst_valid=1}; addresses never skip.
- stall=1 for 2 cycles as the word for 0x8 returns -> IF/ID keeps 0x4; imem_req=0 in HOLD; after stall drops IF/ID=0x8, then the next request is 0xC.
- ID presents pcsrc=1, branch_taken=1, imm=0x100 while ready=1 at 0xC -> 0xC word discarded, one bubble, next imem_addr=0x100; pcsrc=1 with branch_taken=0 -> no redirect.
- pcsrc=3, rs_data=0x203 during an outstanding request at 0x10 -> DRAIN holds imem_addr=0x10 until ready, its word discarded, next fetch 0x200.
- rst asserted mid-request at 0x40 -> next cycle all outputs at reset values, fetch restarts at RESET_PC; with IF_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, imem request handshake, one-entry stall buffer, IF/ID register.
// Define IF_PERF_CNT_EN to add saturating fetch_cnt/bubble_cnt outputs.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);
    localparam logic [1:0] REQ   = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        req_q;
    logic [31:0] pc_q, inst_q;
    logic        valid_q;

    logic        take, ready;
    logic [31:0] target, fetch_pc_inc;
    logic        load_valid;
    logic [31:0] load_pc, load_inst;

    assign take = valid_q & ~stall &
                  ((pcsrc == 2'd2) | (pcsrc == 2'd3) | ((pcsrc == 2'd1) & branch_taken));
    assign target       = (pcsrc == 2'd3) ? (rs_data & 32'hFFFF_FFFC) : imm;
    assign fetch_pc_inc = fetch_pc_q + 32'd4;
    // req_q is low for the first cycle out of reset, so a late response to an aborted request
    // is never mistaken for a fresh one.
    assign ready = imem_ready & req_q;

    // Whenever stall is low IF/ID is reloaded; a bubble unless a valid word is selected below.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        hold_inst_d  = hold_inst_q;
        load_valid   = 1'b0;
        load_pc      = pc_q;
        load_inst    = NOP_INST;
        case (state_q)
            REQ: begin
                if (take) begin
                    fetch_pc_d = target;
                    if (!ready) begin
                        state_d      = DRAIN;
                        drain_addr_d = fetch_pc_q;
                    end
                end else if (ready && stall) begin
                    hold_inst_d = imem_rdata;
                    fetch_pc_d  = fetch_pc_inc;
                    state_d     = HOLD;
                end else if (ready) begin
                    load_valid = 1'b1;
                    load_pc    = fetch_pc_q;
                    load_inst  = imem_rdata;
                    fetch_pc_d = fetch_pc_inc;
                end
            end
            HOLD: begin
                if (take) begin
                    fetch_pc_d = target;
                    state_d    = REQ;
                end else if (!stall) begin
                    load_valid = 1'b1;
                    load_pc    = fetch_pc_q - 32'd4;
                    load_inst  = hold_inst_q;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                if (take) begin
                    fetch_pc_d = target;
                end
                if (ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
            hold_inst_q  <= NOP_INST;
            req_q        <= 1'b0;
            pc_q         <= 32'h0000_0000;
            inst_q       <= NOP_INST;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            hold_inst_q  <= hold_inst_d;
            req_q        <= (state_d != HOLD);
            if (!stall) begin
                pc_q    <= load_pc;
                inst_q  <= load_inst;
                valid_q <= load_valid;
            end
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else if (!stall) begin
            if (load_valid) begin
                if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                if (bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed walk through fetch, latency, stall, redirect, drain, wrap and
// reset, then a randomized run checked against a program-order model of the fetch stream.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pcsrc = 2'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs_data = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc, inst;
    logic        inst_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt;
`endif

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .pcsrc        (pcsrc),
        .branch_taken (branch_taken),
        .imm          (imm),
        .rs_data      (rs_data),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .inst         (inst),
        .inst_valid   (inst_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic rdy);
        imem_ready = rdy;
        imem_rdata = rdy ? inst_of(imem_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic expect_if(input string tag, input logic [31:0] addr, input logic req,
                             input logic valid, input logic [31:0] exp_pc);
        chk({tag, "_addr"}, imem_addr, addr);
        chk({tag, "_req"}, {31'h0, imem_req}, {31'h0, req});
        chk({tag, "_valid"}, {31'h0, inst_valid}, {31'h0, valid});
        if (valid) begin
            chk({tag, "_pc"}, pc, exp_pc);
            chk({tag, "_inst"}, inst, inst_of(exp_pc));
        end
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, "_req"}, {31'h0, imem_req}, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk({tag, "_fcnt"}, fetch_cnt, 32'h0);
        chk({tag, "_bcnt"}, bubble_cnt, 32'h0);
`endif
    endtask

    logic [31:0] exp_pc, cur_pc, p_pc, p_inst, p_addr, tgt;
    logic        p_valid, p_stall, p_take, p_wait;
    int          n_valid, m_fetch, m_bubble;

    initial begin
        // Reset, then zero-wait memory: one instruction per cycle.
        mem(1'b0);
        tick();
        tick();
        expect_reset("reset");
        rst = 1'b0;
        mem(1'b1);
        tick();
        expect_if("start", 32'h0, 1'b1, 1'b0, 32'h0);
        mem(1'b1);
        tick();
        expect_if("zw0", 32'h4, 1'b1, 1'b1, 32'h0);
        for (int i = 1; i < 4; i++) begin
            mem(1'b1);
            tick();
            expect_if("zw", 32'(4 * (i + 1)), 1'b1, 1'b1, 32'(4 * i));
        end

        // Three-cycle latency at 0x10: two bubbles, address held.
        mem(1'b0);
        tick();
        expect_if("lat1", 32'h10, 1'b1, 1'b0, 32'h0);
        mem(1'b0);
        tick();
        expect_if("lat2", 32'h10, 1'b1, 1'b0, 32'h0);
        mem(1'b1);
        tick();
        expect_if("lat3", 32'h14, 1'b1, 1'b1, 32'h10);

        // Stall as the word for 0x14 returns: IF/ID holds 0x10, no request while held.
        stall = 1'b1;
        mem(1'b1);
        tick();
        chk("stall1_req", {31'h0, imem_req}, 32'h0);
        chk("stall1_pc", pc, 32'h10);
        chk("stall1_valid", {31'h0, inst_valid}, 32'h1);
        mem(1'b0);
        tick();
        chk("stall2_req", {31'h0, imem_req}, 32'h0);
        chk("stall2_pc", pc, 32'h10);
        stall = 1'b0;
        tick();
        expect_if("unstall", 32'h18, 1'b1, 1'b1, 32'h14);

        // Branch not taken, then taken while the 0x1C word returns.
        pcsrc = 2'd1;
        branch_taken = 1'b0;
        imm = 32'h300;
        mem(1'b1);
        tick();
        expect_if("bnt", 32'h1C, 1'b1, 1'b1, 32'h18);
        branch_taken = 1'b1;
        imm = 32'h100;
        mem(1'b1);
        tick();
        expect_if("bt", 32'h100, 1'b1, 1'b0, 32'h0);
        pcsrc = 2'd0;
        branch_taken = 1'b0;
        mem(1'b1);
        tick();
        expect_if("bt_tgt", 32'h104, 1'b1, 1'b1, 32'h100);

        // Jump-register during an outstanding request at 0x104: drain, then fetch 0x200.
        pcsrc = 2'd3;
        rs_data = 32'h203;
        mem(1'b0);
        tick();
        expect_if("drain1", 32'h104, 1'b1, 1'b0, 32'h0);
        pcsrc = 2'd0;
        mem(1'b0);
        tick();
        expect_if("drain2", 32'h104, 1'b1, 1'b0, 32'h0);
        mem(1'b1);
        tick();
        expect_if("drain3", 32'h200, 1'b1, 1'b0, 32'h0);
        mem(1'b1);
        tick();
        expect_if("jr_tgt", 32'h204, 1'b1, 1'b1, 32'h200);

        // Jump to the top word: the next fetch address wraps to 0.
        pcsrc = 2'd2;
        imm = 32'hFFFF_FFFC;
        mem(1'b1);
        tick();
        expect_if("j_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
        pcsrc = 2'd0;
        mem(1'b1);
        tick();
        expect_if("wrap", 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);

        // Reset while a request at 0x40 is outstanding; its late response must be ignored.
        pcsrc = 2'd2;
        imm = 32'h40;
        mem(1'b1);
        tick();
        expect_if("j40", 32'h40, 1'b1, 1'b0, 32'h0);
        pcsrc = 2'd0;
        mem(1'b0);
        tick();
        rst = 1'b1;
        mem(1'b1);
        tick();
        expect_reset("midrst");
        rst = 1'b0;
        mem(1'b1);
        tick();
        expect_if("late_rdy", 32'h0, 1'b1, 1'b0, 32'h0);
        mem(1'b1);
        tick();
        expect_if("restart", 32'h4, 1'b1, 1'b1, 32'h0);

        // Randomized run against a program-order model of the IF/ID stream.
        rst = 1'b1;
        mem(1'b0);
        tick();
        rst = 1'b0;
        exp_pc = 32'h0;
        cur_pc = 32'h0;
        n_valid = 0;
        m_fetch = 0;
        m_bubble = 0;
        for (int c = 0; c < 1500; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            pcsrc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            branch_taken = 1'($urandom_range(0, 1));
            imm = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
            rs_data = $urandom;
            mem(imem_req && ($urandom_range(0, 1) == 1));
            tgt = (pcsrc == 2'd3) ? {rs_data[31:2], 2'b00} : imm;
            p_take = inst_valid && !stall &&
                     (pcsrc == 2'd2 || pcsrc == 2'd3 || (pcsrc == 2'd1 && branch_taken));
            if (inst_valid && !stall) exp_pc = p_take ? tgt : cur_pc + 32'd4;
            p_stall = stall;
            p_pc = pc;
            p_inst = inst;
            p_valid = inst_valid;
            p_addr = imem_addr;
            p_wait = imem_req && !imem_ready;
            tick();
            if (p_stall) begin
                chk("r_hold_pc", pc, p_pc);
                chk("r_hold_inst", inst, p_inst);
                chk("r_hold_valid", {31'h0, inst_valid}, {31'h0, p_valid});
            end else begin
                if (p_take) chk("r_squash", {31'h0, inst_valid}, 32'h0);
                if (inst_valid) begin
                    chk("r_pc", pc, exp_pc);
                    chk("r_inst", inst, inst_of(exp_pc));
                    cur_pc = exp_pc;
                    n_valid++;
                    m_fetch++;
                end else begin
                    m_bubble++;
                end
            end
            if (p_wait) chk("r_addr_stable", imem_addr, p_addr);
            if (imem_req) chk("r_addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
        end
        chk("r_progress", {31'h0, (n_valid >= 100)}, 32'h1);
`ifdef IF_PERF_CNT_EN
        chk("r_fetch_cnt", fetch_cnt, 32'(m_fetch));
        chk("r_bubble_cnt", bubble_cnt, 32'(m_bubble));
`endif
        $display("random phase: %0d instructions, %0d bubbles", m_fetch, m_bubble);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
